// File: rtl/ahb_dma_master.sv
// AHB-Lite single-transfer DMA copy engine: moves len 32-bit words from src to dst, one read then
// one write per word. Define AHB_DMA_MASTER_IRQ_EN to enable the sticky irq output.
module ahb_dma_master #(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned WAIT_IDLE = 0
) (
  input  logic             sys_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             irq_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             irq,
  output logic [LEN_W-1:0] words_done,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  // GAP always lasts at least one cycle, even when no idle cycles are requested.
  localparam int unsigned GapCycles = (WAIT_IDLE == 0) ? 1 : WAIT_IDLE;
  localparam logic [3:0]  GapLast   = 4'(GapCycles - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrA,
    StWrD,
    StGap,
    StFin
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] words_inc;
  logic             last_word;

  assign words_inc = words_q + {{(LEN_W-1){1'b0}}, 1'b1};
  assign last_word = (words_inc == len_q);

  // State register
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (len == '0) ? StFin : StRdA;
        end
      end
      StRdA: begin
        if (HREADY) state_d = StRdD;
      end
      StRdD: begin
        if (HRESP) begin
          state_d = StFin;
        end else if (HREADY) begin
          state_d = StWrA;
        end
      end
      StWrA: begin
        if (HREADY) state_d = StWrD;
      end
      StWrD: begin
        if (HRESP) begin
          state_d = StFin;
        end else if (HREADY) begin
          state_d = last_word ? StFin : StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) state_d = StRdA;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    data_d    = data_q;
    words_d   = words_q;
    err_d     = err_q;
    gap_cnt_d = '0;
    // done is registered, so it pulses in the cycle after FIN.
    done_d    = (state_q == StFin);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = {src_addr[31:2], 2'b00};
          dst_d   = {dst_addr[31:2], 2'b00};
          len_d   = len;
          words_d = '0;
          err_d   = 1'b0;
        end
      end
      StRdD: begin
        if (HRESP) begin
          err_d = 1'b1;
        end else if (HREADY) begin
          data_d = HRDATA;
        end
      end
      StWrD: begin
        if (HRESP) begin
          err_d = 1'b1;
        end else if (HREADY) begin
          words_d = words_inc;
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
        end
      end
      StGap:   gap_cnt_d = gap_cnt_q + 4'd1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      words_q   <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      data_q    <= data_d;
      words_q   <= words_d;
      gap_cnt_q <= gap_cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Bus outputs; HADDR keeps the phase address through the data phase so stalls see it stable.
  always_comb begin
    HADDR  = 32'h0;
    HTRANS = HtransIdle;
    HWRITE = 1'b0;
    HWDATA = 32'h0;
    busy   = (state_q != StIdle);
    unique case (state_q)
      StRdA: begin
        HADDR  = src_q;
        HTRANS = HtransNonseq;
      end
      StRdD: HADDR = src_q;
      StWrA: begin
        HADDR  = dst_q;
        HTRANS = HtransNonseq;
        HWRITE = 1'b1;
      end
      StWrD: begin
        HADDR  = dst_q;
        HWDATA = data_q;
      end
      default: ;
    endcase
  end

  assign HSIZE      = 3'b010;
  assign HBURST     = 3'b000;
  assign HPROT      = 4'b0011;
  assign HMASTLOCK  = 1'b0;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_q;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

`ifdef AHB_DMA_MASTER_IRQ_EN
  logic irq_q, irq_d;

  // Set wins over a simultaneous clear.
  always_comb begin
    irq_d = irq_q;
    if (state_q == StFin) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_dma_master.sv
// Scoreboard bench for ahb_dma_master: a behavioural slave answers the bus, a reference model
// predicts reads, writes and the completion pulse, and a monitor checks what the DUT presents.
module tb_ahb_dma_master;

  localparam int unsigned LenW      = 16;
  localparam int unsigned WaitIdle  = 0;
  localparam int unsigned GapCycles = (WaitIdle == 0) ? 1 : WaitIdle;
  localparam int          MaxDp     = 64;
  localparam logic [1:0]  Nonseq    = 2'b10;

  logic            sys_clock;
  logic            reset;
  logic            start;
  logic [31:0]     src_addr;
  logic [31:0]     dst_addr;
  logic [LenW-1:0] len;
  logic            irq_clr;
  logic            busy;
  logic            done;
  logic            err;
  logic            irq;
  logic [LenW-1:0] words_done;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic            HMASTLOCK;
  logic [31:0]     HWDATA;
  logic [31:0]     HRDATA;
  logic            HREADY;
  logic            HRESP;

  ahb_dma_master #(
    .LEN_W     (LenW),
    .WAIT_IDLE (WaitIdle)
  ) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .irq_clr    (irq_clr),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .irq        (irq),
    .words_done (words_done),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HMASTLOCK  (HMASTLOCK),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int unsigned words;
    int unsigned errf;
    int          cyc;
    int unsigned busy_cycles;
  } done_t;

  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  done_t       exp_done[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;
  int stall_tab[MaxDp];
  int slv_dp_idx = 0;
  int slv_err_dp = -1;

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  initial begin
    forever begin
      @(posedge sys_clock);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Slave memory contents: a few fixed words, otherwise a hash of the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h1C00_0800: return 32'h0000_0011;
      32'h1C00_0804: return 32'h0000_0022;
      32'h1C00_0808: return 32'h0000_0033;
      default:       return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endcase
  endfunction

  // Behavioural AHB-Lite slave: samples the bus at negedge, drives responses just after posedge.
  initial begin
    logic        c_ap, c_write, c_rdy, c_rst;
    logic [31:0] c_addr, s_addr;
    logic        s_dp, s_write, s_err;
    int          s_stall;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    s_dp   = 1'b0;
    s_addr = '0;
    s_write = 1'b0;
    s_err  = 1'b0;
    s_stall = 0;
    forever begin
      @(negedge sys_clock);
      c_ap    = (HTRANS == Nonseq);
      c_addr  = HADDR;
      c_write = HWRITE;
      c_rdy   = HREADY;
      c_rst   = reset;
      @(posedge sys_clock);
      #1;
      if (c_rst) begin
        s_dp = 1'b0;
      end else begin
        if (s_dp && c_rdy) s_dp = 1'b0;
        if (c_ap && c_rdy) begin
          s_dp    = 1'b1;
          s_addr  = c_addr;
          s_write = c_write;
          s_stall = stall_tab[slv_dp_idx % MaxDp];
          s_err   = (slv_dp_idx == slv_err_dp);
          slv_dp_idx++;
        end
      end
      HRDATA = $urandom;
      HRESP  = 1'b0;
      HREADY = 1'b1;
      if (s_dp) begin
        if (s_stall > 0) begin
          HREADY = 1'b0;
          s_stall--;
        end else begin
          HRESP = s_err;
          if (!s_write) HRDATA = mem_val(s_addr);
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        m_dp, m_write, m_irq, rst_prev, clr_prev, is_exp;
    logic [31:0] m_addr, m_prev_haddr, m_prev_hwdata, ra;
    int          m_dcyc;
    int unsigned m_busy;
    done_t       e;
    wr_t         w;
    m_dp = 1'b0;
    m_write = 1'b0;
    m_irq = 1'b0;
    rst_prev = 1'b1;
    clr_prev = 1'b0;
    m_addr = '0;
    m_prev_haddr = '0;
    m_prev_hwdata = '0;
    m_dcyc = 0;
    m_busy = 0;
    forever begin
      @(negedge sys_clock);
      is_exp = (exp_done.size() != 0) && (exp_done[0].cyc == cyc);
`ifdef AHB_DMA_MASTER_IRQ_EN
      if (rst_prev) m_irq = 1'b0;
      else if (is_exp) m_irq = 1'b1;
      else if (clr_prev) m_irq = 1'b0;
`else
      m_irq = 1'b0;
`endif
      chk("irq", irq, m_irq);
      chk("htrans_kind", HTRANS[0], 1'b0);
      chk("done", done, is_exp);
      if (done) last_done_cyc = cyc;
      if (is_exp) begin
        e = exp_done.pop_front();
        chk("words_done", 32'(words_done), e.words);
        chk("err", err, e.errf);
        chk("busy_cycles", m_busy, e.busy_cycles);
        chk("reads_left", exp_rd.size(), 0);
        chk("writes_left", exp_wr.size(), 0);
        m_busy = 0;
        done_cnt++;
      end
      if (busy) m_busy++;
      if (reset) begin
        m_dp = 1'b0;
        m_busy = 0;
      end else begin
        if (!(m_dp && m_write)) chk("hwdata_zero", HWDATA, 32'h0);
        if (m_dp) begin
          chk("dp_htrans", HTRANS, 2'b00);
          if (m_dcyc > 0) begin
            chk("haddr_hold", HADDR, m_prev_haddr);
            if (m_write) chk("hwdata_hold", HWDATA, m_prev_hwdata);
          end
          m_prev_haddr  = HADDR;
          m_prev_hwdata = HWDATA;
          m_dcyc++;
          if (HREADY) begin
            if (m_write) begin
              chk("write_expected", exp_wr.size() != 0, 1'b1);
              if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("wr_addr", m_addr, w.addr);
                chk("wr_data", HWDATA, w.data);
              end
            end
            m_dp = 1'b0;
          end
        end
        if (HTRANS == Nonseq && HREADY) begin
          chk("ctrl", {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
          m_dp    = 1'b1;
          m_addr  = HADDR;
          m_write = HWRITE;
          m_dcyc  = 0;
          if (!HWRITE) begin
            chk("read_expected", exp_rd.size() != 0, 1'b1);
            if (exp_rd.size() != 0) begin
              ra = exp_rd.pop_front();
              chk("rd_addr", HADDR, ra);
            end
          end
        end
      end
      rst_prev = reset;
      clr_prev = irq_clr;
    end
  end

  // Reference model + start pulse. stall < 0 picks random 0..2 stalls per data phase.
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int unsigned l,
                       input int err_dp, input int stall);
    logic [31:0] sm, dm, ra, wa;
    int unsigned cycles, nw, ef;
    wr_t         w;
    done_t       e;
    sm = {s[31:2], 2'b00};
    dm = {d[31:2], 2'b00};
    for (int i = 0; i < MaxDp; i++) stall_tab[i] = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
    cycles = 0;
    nw = 0;
    ef = 0;
    for (int i = 0; i < int'(l); i++) begin
      ra = sm + 32'(4 * i);
      wa = dm + 32'(4 * i);
      exp_rd.push_back(ra);
      cycles += 2 + stall_tab[2 * i];
      if (err_dp == 2 * i) begin
        ef = 1;
        break;
      end
      w.addr = wa;
      w.data = mem_val(ra);
      exp_wr.push_back(w);
      cycles += 2 + stall_tab[2 * i + 1];
      if (err_dp == 2 * i + 1) begin
        ef = 1;
        break;
      end
      nw++;
      if (i + 1 < int'(l)) cycles += GapCycles;
    end
    slv_err_dp = err_dp;
    slv_dp_idx = 0;
    @(posedge sys_clock);
    #1;
    start     = 1'b1;
    src_addr  = s;
    dst_addr  = d;
    len       = LenW'(l);
    start_cyc = cyc;
    e.words = nw;
    e.errf = ef;
    e.cyc = cyc + 2 + int'(cycles);
    e.busy_cycles = 1 + cycles;
    exp_done.push_back(e);
    @(posedge sys_clock);
    #1;
    start    = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    len      = LenW'($urandom);
  endtask

  task automatic wait_done(input bit poke);
    int base, waited;
    base = done_cnt;
    waited = 0;
    while (done_cnt == base && waited < 2000) begin
      @(posedge sys_clock);
      #1;
      start   = poke && busy && ($urandom_range(0, 7) == 0);
      irq_clr = poke && ($urandom_range(0, 3) == 0);
      waited++;
    end
    start = 1'b0;
    irq_clr = 1'b0;
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL timeout: no completion after %0d cycles", waited);
    end
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] d, input int unsigned l,
                     input int err_dp, input int stall, input bit poke);
    issue(s, d, l, err_dp, stall);
    wait_done(poke);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_htrans"}, HTRANS, 2'b00);
    chk({tag, "_haddr"}, HADDR, 32'h0);
    chk({tag, "_hwrite"}, HWRITE, 1'b0);
    chk({tag, "_hwdata"}, HWDATA, 32'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_irq"}, irq, 1'b0);
    chk({tag, "_words"}, 32'(words_done), 32'h0);
  endtask

  initial begin
    int found;
    reset    = 1'b1;
    start    = 1'b0;
    src_addr = 32'hDEAD_BEEF;
    dst_addr = 32'h1234_5678;
    len      = 16'd5;
    irq_clr  = 1'b0;
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    check_reset_state("rst");
    chk("const_bus", {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
    @(posedge sys_clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge sys_clock);
    #1;

    // Three-word copy with zero-wait slave
    run(32'h1C00_0800, 32'h1C00_1000, 3, -1, 0, 1'b0);
    chk("lat_len3", last_done_cyc - start_cyc, 16);
    // Zero length
    run(32'h1C00_0800, 32'h1C00_1000, 0, -1, 0, 1'b0);
    chk("lat_len0", last_done_cyc - start_cyc, 2);
    // Two stalls on every data phase: exactly 8 extra cycles over zero-wait (11)
    run(32'h2000_0000, 32'h3000_0000, 2, -1, 2, 1'b0);
    chk("lat_stall", last_done_cyc - start_cyc, 19);
    // Error on second write
    run(32'h4000_0010, 32'h5000_0020, 4, 3, 0, 1'b0);
    // Error on a read
    run(32'h4000_0100, 32'h5000_0200, 3, 2, 1, 1'b0);
    // Address wrap and unaligned addresses
    run(32'hFFFF_FFFC, 32'h6000_0000, 2, -1, 0, 1'b0);
    run(32'h1C00_0803, 32'h7000_0007, 3, -1, 0, 1'b0);

    // Reset during the write address phase of the second word
    issue(32'h1C00_0800, 32'h1C00_2000, 4, -1, 0);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (HTRANS == Nonseq && HWRITE && words_done == 16'd1) begin
        found = 1;
        reset = 1'b1;
      end else begin
        @(posedge sys_clock);
        #1;
      end
    end
    chk("rst_point_found", found, 1);
    @(posedge sys_clock);
    #1;
    reset = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    exp_done.delete();
    @(negedge sys_clock);
    check_reset_state("midrst");
    repeat (25) @(posedge sys_clock);
    #1;
    run(32'h1C00_0800, 32'h1C00_3000, 3, -1, 0, 1'b0);

    // Randomised transfers with random stalls, errors, ignored starts and irq clears
    for (int t = 0; t < 25; t++) begin
      int unsigned l;
      int edp;
      l = $urandom_range(0, 6);
      edp = -1;
      if (l != 0 && $urandom_range(0, 3) == 0) edp = int'($urandom_range(0, 2 * l - 1));
      run($urandom, $urandom, l, edp, -1, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge sys_clock);
      #1;
    end

    repeat (10) @(posedge sys_clock);
    @(negedge sys_clock);
    chk("final_reads_left", exp_rd.size(), 0);
    chk("final_writes_left", exp_wr.size(), 0);
    chk("final_done_left", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
